// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
// Elastic inter-stage pipeline register for the five-stage MIPS core.
// Carries NCH payload channels of WIDTH bits plus an exception code and a
// branch-delay flag. It uses a valid/ready handshake with a two-entry
// (main + skid) buffer, flush-to-bubble and a saturating stall counter.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   in_valid/in_ready       upstream handshake (in_ready is registered)
//   in_data/in_exc/in_bd    incoming slot
//   flush                   drop all held and incoming slots this cycle
//   out_valid/out_ready     downstream handshake
//   out_data/out_exc/out_bd main-entry slot; all-zero when invalid
//   occupancy               number of valid entries, 0..2
//   stall_cnt               saturating count of out_valid & ~out_ready cycles
module pipe_stage_reg #(
  parameter int WIDTH = 32,
  parameter int NCH   = 8,
  parameter int CNTW  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NCH*WIDTH-1:0]   in_data,
  input  logic [4:0]             in_exc,
  input  logic                   in_bd,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NCH*WIDTH-1:0]   out_data,
  output logic [4:0]             out_exc,
  output logic                   out_bd,
  output logic [1:0]             occupancy,
  output logic [CNTW-1:0]        stall_cnt
);

  localparam int DW = NCH * WIDTH;

  logic          main_valid, skid_valid;
  logic [DW-1:0] main_data, skid_data;
  logic [4:0]    main_exc, skid_exc;
  logic          main_bd, skid_bd;

  logic accept, consume;

  always_comb begin
    accept  = in_valid & in_ready;
    consume = main_valid & out_ready;
  end

  // skid_valid is a register, so in_ready has no path from out_ready.
  assign in_ready  = ~skid_valid;
  assign out_valid = main_valid;
  // Invalid entries already hold zeros; the gating keeps bubbles clean
  // even if a stale field were ever left behind.
  assign out_data  = main_valid ? main_data : '0;
  assign out_exc   = main_valid ? main_exc  : '0;
  assign out_bd    = main_valid & main_bd;
  assign occupancy = 2'(main_valid) + 2'(skid_valid);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      main_valid <= 1'b0;
      main_data  <= '0;
      main_exc   <= '0;
      main_bd    <= 1'b0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_exc   <= '0;
      skid_bd    <= 1'b0;
    end else if (!main_valid || consume) begin
      if (skid_valid) begin
        // Skid always drains ahead of newer input to preserve order.
        main_valid <= 1'b1;
        main_data  <= skid_data;
        main_exc   <= skid_exc;
        main_bd    <= skid_bd;
        skid_valid <= accept;
        skid_data  <= accept ? in_data : '0;
        skid_exc   <= accept ? in_exc  : '0;
        skid_bd    <= accept & in_bd;
      end else if (accept) begin
        main_valid <= 1'b1;
        main_data  <= in_data;
        main_exc   <= in_exc;
        main_bd    <= in_bd;
      end else begin
        main_valid <= 1'b0;
        main_data  <= '0;
        main_exc   <= '0;
        main_bd    <= 1'b0;
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_data  <= in_data;
      skid_exc   <= in_exc;
      skid_bd    <= in_bd;
    end
  end

  // Flush does not clear the counter; it keeps counting stalled edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (main_valid && !out_ready && (stall_cnt != {CNTW{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;
  localparam int WIDTH = 32;
  localparam int NCH   = 8;
  localparam int CNTW  = 16;
  localparam int DW    = NCH * WIDTH;
  localparam int MAXC  = (1 << CNTW) - 1;

  logic            clk, reset, in_valid, in_ready, in_bd, flush;
  logic            out_valid, out_ready, out_bd;
  logic [DW-1:0]   in_data, out_data;
  logic [4:0]      in_exc, out_exc;
  logic [1:0]      occupancy;
  logic [CNTW-1:0] stall_cnt;

  pipe_stage_reg #(.WIDTH(WIDTH), .NCH(NCH), .CNTW(CNTW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_exc(in_exc), .in_bd(in_bd), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_exc(out_exc), .out_bd(out_bd), .occupancy(occupancy),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic [4:0]    exc;
    logic          bd;
  } slot_t;

  // Reference: an in-order store of at most two slots plus a stall tally.
  slot_t q[$];
  int    stall_m = 0;
  bit    known = 0;
  int    checks = 0;
  int    failures = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard: compare at negedge, then advance the model
  // by the upcoming edge using the inputs that are stable now.
  initial begin
    int    n;
    bit    acc, cons;
    slot_t s;
    forever begin
      @(negedge clk);
      if (known) begin
        n = q.size();
        chk("out_valid", DW'(out_valid), DW'(n > 0));
        chk("occupancy", DW'(occupancy), DW'(n));
        chk("in_ready",  DW'(in_ready),  DW'(n < 2));
        chk("stall_cnt", DW'(stall_cnt), DW'(stall_m));
        if (n == 0) begin
          chk("bubble_data", out_data, '0);
          chk("bubble_exc",  DW'(out_exc), '0);
          chk("bubble_bd",   DW'(out_bd),  '0);
        end else if (out_ready) begin
          chk("slot_data", out_data, q[0].data);
          chk("slot_exc",  DW'(out_exc), DW'(q[0].exc));
          chk("slot_bd",   DW'(out_bd),  DW'(q[0].bd));
        end
      end
      if (reset) begin
        q.delete();
        stall_m = 0;
        known = 1;
      end else if (known) begin
        if (q.size() > 0 && !out_ready && stall_m != MAXC) stall_m++;
        if (flush) begin
          q.delete();
        end else begin
          acc  = in_valid && (q.size() < 2);
          cons = (q.size() > 0) && out_ready;
          if (cons) void'(q.pop_front());
          if (acc) begin
            s.data = in_data;
            s.exc  = in_exc;
            s.bd   = in_bd;
            q.push_back(s);
          end
        end
      end
    end
  end

  task automatic cyc(input logic v, input logic [DW-1:0] d, input logic [4:0] e,
                     input logic b, input logic ordy, input logic fl = 1'b0,
                     input logic rs = 1'b0);
    in_valid  = v;
    in_data   = d;
    in_exc    = e;
    in_bd     = b;
    out_ready = ordy;
    flush     = fl;
    reset     = rs;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] r;
    for (int i = 0; i < NCH; i++) r[i*WIDTH +: WIDTH] = WIDTH'($urandom);
    return r;
  endfunction

  initial begin
    in_valid = 0; in_data = '0; in_exc = '0; in_bd = 0;
    out_ready = 0; flush = 0; reset = 1;
    cyc(0, '0, 0, 0, 1, 0, 1);
    cyc(0, '0, 0, 0, 1, 0, 1);

    // Streaming with out_ready held high.
    cyc(1, 'h11, 0, 0, 1);
    cyc(1, 'h22, 0, 0, 1);
    cyc(1, 'h33, 0, 0, 1);
    cyc(0, '0, 0, 0, 1);
    cyc(0, '0, 0, 0, 1);

    // Backpressure: A, B fill, C refused until drain.
    cyc(1, 'hA, 0, 0, 0);
    cyc(1, 'hB, 0, 0, 0);
    cyc(1, 'hC, 0, 0, 0);
    cyc(1, 'hC, 0, 0, 0);
    cyc(1, 'hC, 0, 0, 1);
    cyc(1, 'hC, 0, 0, 1);
    cyc(0, '0, 0, 0, 1);
    cyc(0, '0, 0, 0, 1);

    // Flush with both entries full and an input offered.
    cyc(1, 'hD1, 0, 0, 0);
    cyc(1, 'hD2, 0, 0, 0);
    cyc(1, 'hDF, 0, 0, 0, 1);
    cyc(0, '0, 0, 0, 1);
    cyc(0, '0, 0, 0, 1);

    // Exception tags then a bubble.
    cyc(1, 'h1234, 5'd12, 1, 1);
    cyc(0, '0, 0, 0, 1);
    cyc(0, '0, 0, 0, 1);

    // Reset while full, then first slot after reset.
    cyc(1, 'hE1, 0, 0, 0);
    cyc(1, 'hE2, 0, 0, 0);
    cyc(1, 'hE3, 0, 0, 0, 0, 1);
    cyc(1, 'hF1, 0, 0, 1);
    cyc(0, '0, 0, 0, 1);
    cyc(0, '0, 0, 0, 1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++)
      cyc(($urandom % 4) != 0, rnd_data(), 5'($urandom), 1'($urandom),
          ($urandom % 3) != 0, ($urandom % 50) == 0);

    // Stall counter saturation.
    cyc(0, '0, 0, 0, 1, 0, 1);
    cyc(1, 'h77, 0, 0, 0);
    for (int i = 0; i < 66000; i++) cyc(0, '0, 0, 0, 0);
    checks++;
    if (stall_cnt !== CNTW'(MAXC)) begin
      failures++;
      $display("FAIL stall_sat actual=%0d required=%0d", stall_cnt, MAXC);
    end
    cyc(0, '0, 0, 0, 1);
    cyc(0, '0, 0, 0, 1);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
